pit_ctrl: RTL

Host-side controller for the three 8253/8254 PIT counter channels in the SoC. It decodes the four PIT I/O registers (counter 0/1/2 data and the control word) into per-channel command strobes, including the 8254 read-back command. It also muxes and registers read data, generates the PIT input clock from the system clock, and derives the timer IRQ pulse from channel 0's output. It sits between the I/O bus decoder and three counter channel instances.

---
 rtl/pit_pkg.sv | 28 ++
 rtl/pit_clock_gen.sv | 39 +++
 rtl/pit_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/pit_pkg.sv
// Shared constants for the PIT host controller: register offsets and control-word fields.
package pit_pkg;

    localparam logic [1:0] PIT_CH0  = 2'd0;
    localparam logic [1:0] PIT_CH1  = 2'd1;
    localparam logic [1:0] PIT_CH2  = 2'd2;
    localparam logic [1:0] PIT_CTRL = 2'd3;

    localparam int SC_HI       = 7;
    localparam int SC_LO       = 6;
    localparam int RW_HI       = 5;
    localparam int RW_LO       = 4;
    localparam int RB_MASK_HI  = 3;
    localparam int RB_MASK_LO  = 1;
    localparam int RB_COUNT_N  = 5;
    localparam int RB_STATUS_N = 4;

    localparam logic [1:0] RW_LATCH = 2'd0;

    // One-hot channel select; the control-word offset maps to no channel.
    function automatic logic [2:0] ch_sel(input logic [1:0] idx);
        logic [2:0] r;
        r = 3'b000;
        if (idx != PIT_CTRL) r = 3'b001 << idx;
        return r;
    endfunction

endpackage

// File: rtl/pit_clock_gen.sv
// Fractional PIT clock generator: phase accumulator toggles pit_clock at 2*PIT_HZ steps.
module pit_clock_gen
    import pit_pkg::*;
#(
    parameter int CLK_HZ = 30000000,
    parameter int PIT_HZ = 1193182
) (
    input  logic clk,
    input  logic rst,
    output logic pit_clock
);

    localparam logic [32:0] STEP  = 33'(longint'(PIT_HZ) * 2);
    localparam logic [32:0] LIMIT = 33'(longint'(CLK_HZ));

    generate
        if (longint'(PIT_HZ) * 2 >= longint'(CLK_HZ)) begin : g_bad_ratio
            $error("pit_clock_gen: 2*PIT_HZ must be below CLK_HZ");
        end
    endgenerate

    logic [31:0] acc;
    logic [32:0] sum;

    assign sum = {1'b0, acc} + STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            pit_clock <= 1'b0;
        end else if (sum >= LIMIT) begin
            acc       <= 32'(sum - LIMIT);
            pit_clock <= ~pit_clock;
        end else begin
            acc <= sum[31:0];
        end
    end

endmodule

// File: rtl/pit_ctrl.sv
// PIT host controller: I/O register decode to channel strobes, read mux, PIT clock, timer IRQ.
// Define PIT_READBACK_EN to decode the 8254 read-back command (SC = 3).
module pit_ctrl
    import pit_pkg::*;
#(
    parameter int CLK_HZ = 30000000,
    parameter int PIT_HZ = 1193182
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] io_address,
    input  logic       io_read,
    input  logic       io_write,
    input  logic [7:0] io_writedata,
    output logic [7:0] io_readdata,
    output logic [7:0] ch_data_in,
    output logic [2:0] ch_set_control_mode,
    output logic [2:0] ch_latch_count,
    output logic [2:0] ch_latch_status,
    output logic [2:0] ch_write,
    output logic [2:0] ch_read,
    input  logic [7:0] ch0_data_out,
    input  logic [7:0] ch1_data_out,
    input  logic [7:0] ch2_data_out,
    input  logic       ch0_out,
    output logic       pit_clock,
    output logic       irq
);

    logic [1:0] sc;
    logic [1:0] rw;
    logic       ch0_out_d;

    assign ch_data_in = io_writedata;
    assign sc         = io_writedata[SC_HI:SC_LO];
    assign rw         = io_writedata[RW_HI:RW_LO];

    // A write wins over a simultaneous read; nothing strobes during reset.
    always_comb begin
        ch_set_control_mode = 3'b000;
        ch_latch_count      = 3'b000;
        ch_latch_status     = 3'b000;
        ch_write            = 3'b000;
        ch_read             = 3'b000;
        if (!rst) begin
            if (io_write) begin
                if (io_address != PIT_CTRL) begin
                    ch_write = ch_sel(io_address);
                end else if (sc != 2'd3) begin
                    if (rw == RW_LATCH) ch_latch_count      = ch_sel(sc);
                    else                ch_set_control_mode = ch_sel(sc);
                end else begin
`ifdef PIT_READBACK_EN
                    // COUNT# and STATUS# are active low; the mask gates both.
                    if (!io_writedata[RB_COUNT_N])
                        ch_latch_count = io_writedata[RB_MASK_HI:RB_MASK_LO];
                    if (!io_writedata[RB_STATUS_N])
                        ch_latch_status = io_writedata[RB_MASK_HI:RB_MASK_LO];
`endif
                end
            end else if (io_read) begin
                ch_read = ch_sel(io_address);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_readdata <= 8'h00;
        end else if (io_read && !io_write) begin
            case (io_address)
                PIT_CH0: io_readdata <= ch0_data_out;
                PIT_CH1: io_readdata <= ch1_data_out;
                PIT_CH2: io_readdata <= ch2_data_out;
                default: io_readdata <= 8'hFF;
            endcase
        end
    end

    // Channels come out of reset with OUT high, so the delayed copy starts high too.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch0_out_d <= 1'b1;
            irq       <= 1'b0;
        end else begin
            ch0_out_d <= ch0_out;
            irq       <= ch0_out & ~ch0_out_d;
        end
    end

    pit_clock_gen #(
        .CLK_HZ (CLK_HZ),
        .PIT_HZ (PIT_HZ)
    ) u_clock_gen (
        .clk       (clk),
        .rst       (rst),
        .pit_clock (pit_clock)
    );

endmodule
